// File: rtl/fp12_adder_arbiter.sv
// fp12_adder_arbiter
//   Round-robin sequencer that shares one combinational 12-bit FP adder
//   between two requesters. On a granted operation it:
//     - latches the winner's operands onto add_x/add_y,
//     - captures add_z/add_of one cycle later,
//     - pulses done on the winner's port.
//   Occupancy is a fixed three cycles: IDLE -> EXEC -> RESP.
// Parameters
//   W        operand/result width (pass-through, no arithmetic here)
//   RR_INIT  requester that wins the first contested arbitration after reset
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req/x/y{0,1}                request + operands, held until gnt
//   gnt/done{0,1}               one-cycle accept / result-ready pulses
//   z/of{0,1}                   per-port result, held until that port's next done
//   add_x, add_y                registered operands to the shared adder
//   add_z, add_of               adder result (combinational from add_x/add_y)
//   busy                        high whenever an operation is in flight
// Configuration
//   OF_STICKY_EN  when defined, of{0,1} accumulate until reset
//                 instead of tracking the latest result.

module fp12_res_lane #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic [W-1:0] add_z,
  input  logic         add_of,
  output logic [W-1:0] z,
  output logic         of
);
  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      of <= 1'b0;
    end else if (cap) begin
      z  <= add_z;
`ifdef OF_STICKY_EN
      of <= of | add_of;
`else
      of <= add_of;
`endif
    end
  end
endmodule

module fp12_adder_arbiter #(
  parameter int W       = 12,
  parameter int RR_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  output logic         gnt0,
  output logic         done0,
  output logic [W-1:0] z0,
  output logic         of0,
  input  logic         req1,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic         gnt1,
  output logic         done1,
  output logic [W-1:0] z1,
  output logic         of1,
  output logic [W-1:0] add_x,
  output logic [W-1:0] add_y,
  input  logic [W-1:0] add_z,
  input  logic         add_of,
  output logic         busy
);
  localparam int  NUM_LANES = 2;
  localparam logic PTR_RST  = (RR_INIT == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, nxt;
  logic   owner, ptr, win;

  logic [NUM_LANES-1:0]        req, gnt, done, ofv, own_oh;
  logic [NUM_LANES-1:0][W-1:0] xv, yv, zv;

  assign req = {req1, req0};
  assign xv  = {x1, x0};
  assign yv  = {y1, y0};

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    nxt = state;
    win = 1'b0;
    if (req[0] && req[1]) win = ~ptr;
    else                  win = req[1];
    case (state)
      IDLE:    if (|req) nxt = EXEC;
      EXEC:    nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= PTR_RST;
      add_x <= '0;
      add_y <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |req) begin
        add_x <= xv[win];
        add_y <= yv[win];
        owner <= win;
        ptr   <= win;
      end
    end
  end

  assign own_oh = owner ? 2'b10 : 2'b01;
  assign busy   = (state != IDLE);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign gnt[k]  = (state == EXEC) && own_oh[k];
    assign done[k] = (state == RESP) && own_oh[k];
    fp12_res_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .cap    (gnt[k]),
      .add_z  (add_z),
      .add_of (add_of),
      .z      (zv[k]),
      .of     (ofv[k])
    );
  end

  assign gnt0  = gnt[0];
  assign gnt1  = gnt[1];
  assign done0 = done[0];
  assign done1 = done[1];
  assign z0    = zv[0];
  assign z1    = zv[1];
  assign of0   = ofv[0];
  assign of1   = ofv[1];
endmodule

// File: tb/tb_fp12_adder_arbiter.sv
module tb_fp12_adder_arbiter;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [W-1:0] x0, y0, x1, y1;
  logic gnt0, gnt1, done0, done1, of0, of1, busy, add_of;
  logic [W-1:0] z0, z1, add_x, add_y, add_z;
  logic real_mode;

  always #5 clk = ~clk;

  fp12_adder_arbiter #(.W(W), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0), .gnt0(gnt0), .done0(done0), .z0(z0), .of0(of0),
    .req1(req1), .x1(x1), .y1(y1), .gnt1(gnt1), .done1(done1), .z1(z1), .of1(of1),
    .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_of(add_of), .busy(busy)
  );

  // Simple fp12 adder (1/5/6), same-sign normal operands, truncating.
  function automatic logic [12:0] fp12_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] hi, lo;
    logic [4:0]  d;
    logic [7:0]  s;
    logic [5:0]  e;
    if (a[10:6] >= b[10:6]) begin hi = a; lo = b; end
    else                    begin hi = b; lo = a; end
    d = hi[10:6] - lo[10:6];
    s = {2'b01, hi[5:0]} + ({2'b01, lo[5:0]} >> d);
    e = {1'b0, hi[10:6]};
    if (s[7]) begin s = s >> 1; e = e + 6'd1; end
    return {e[5], hi[11], e[4:0], s[5:0]};
  endfunction

  function automatic logic [12:0] adder_ref(input logic [11:0] a, input logic [11:0] b);
    if (real_mode) return fp12_add(a, b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_comb {add_of, add_z} = adder_ref(add_x, add_y);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: an accepted op at cycle A grants at A+1, reports
  // at A+2 and frees the adder at A+3.
  int cyc = 0, acc = -100, free_c = 0;
  logic last = 1'b1, own = 1'b0;
  logic [12:0] res;
  logic [11:0] ez[2], eax, eay;
  logic eof[2];
  int gq[$];
  int done_cnt;

  task automatic model_accept();
    logic w;
    if (rst) begin
      acc = -100; free_c = cyc + 1; last = 1'b1;
      ez[0] = '0; ez[1] = '0; eof[0] = 1'b0; eof[1] = 1'b0; eax = '0; eay = '0;
    end else if (cyc >= free_c && (req0 || req1)) begin
      w = (req0 && req1) ? ~last : req1;
      last = w; own = w; acc = cyc; free_c = cyc + 3;
      eax = w ? x1 : x0;
      eay = w ? y1 : y0;
      res = adder_ref(eax, eay);
    end
  endtask

  task automatic check_outputs();
    if (cyc == acc + 2) begin
      ez[own] = res[11:0];
`ifdef OF_STICKY_EN
      eof[own] = eof[own] | res[12];
`else
      eof[own] = res[12];
`endif
    end
    chk("busy",  16'(busy),  16'(cyc == acc + 1 || cyc == acc + 2));
    chk("gnt0",  16'(gnt0),  16'(cyc == acc + 1 && !own));
    chk("gnt1",  16'(gnt1),  16'(cyc == acc + 1 && own));
    chk("done0", 16'(done0), 16'(cyc == acc + 2 && !own));
    chk("done1", 16'(done1), 16'(cyc == acc + 2 && own));
    chk("z0", 16'(z0), 16'(ez[0]));
    chk("z1", 16'(z1), 16'(ez[1]));
    chk("of0", 16'(of0), 16'(eof[0]));
    chk("of1", 16'(of1), 16'(eof[1]));
    chk("add_x", 16'(add_x), 16'(eax));
    chk("add_y", 16'(add_y), 16'(eay));
    if (gnt0) gq.push_back(0);
    if (gnt1) gq.push_back(1);
    if (done0 || done1) done_cnt++;
  endtask

  task automatic tick();
    model_accept();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_op(input int k, input logic [11:0] a, input logic [11:0] b);
    int n;
    if (k == 0) begin req0 = 1'b1; x0 = a; y0 = b; end
    else        begin req1 = 1'b1; x1 = a; y1 = b; end
    n = 0;
    do begin tick(); n++; end while (!(k ? gnt1 : gnt0) && n < 10);
    chk("op_gnt", 16'(k ? gnt1 : gnt0), 16'd1);
    if (k == 0) req0 = 1'b0; else req1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(k ? done1 : done0) && n < 10);
    chk("op_done", 16'(k ? done1 : done0), 16'd1);
  endtask

  initial begin
    logic [11:0] zsave;
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; real_mode = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    ez[0] = '0; ez[1] = '0; eof[0] = 1'b0; eof[1] = 1'b0; eax = '0; eay = '0;

    // 1: single op latency
    tick(); tick();
    rst = 1'b0;
    req0 = 1'b1; x0 = 12'h360; y0 = 12'h3C0;
    tick();
    chk("t1_gnt0", 16'(gnt0), 16'd1);
    chk("t1_busy1", 16'(busy), 16'd1);
    req0 = 1'b0;
    tick();
    chk("t1_done0", 16'(done0), 16'd1);
    chk("t1_z0", 16'(z0), 16'h720);
    chk("t1_of0", 16'(of0), 16'd0);
    chk("t1_busy2", 16'(busy), 16'd1);
    tick();
    chk("t1_idle", 16'(busy), 16'd0);

    // 2: contested after reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req0 = 1'b1; x0 = 12'h123; y0 = 12'h045;
    req1 = 1'b1; x1 = 12'h210; y1 = 12'h00F;
    tick();
    chk("t2_gnt0", 16'(gnt0), 16'd1);
    req0 = 1'b0;
    tick();
    chk("t2_done0", 16'(done0), 16'd1);
    zsave = z0;
    tick(); tick();
    chk("t2_gnt1", 16'(gnt1), 16'd1);
    req1 = 1'b0;
    tick();
    chk("t2_done1", 16'(done1), 16'd1);
    chk("t2_z0_kept", 16'(z0), 16'(zsave));
    chk("t2_z1", 16'(z1), 16'h21F);
    tick();

    // 3: both held continuously for 12 cycles
    gq.delete(); done_cnt = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_ngnt", 16'(gq.size()), 16'd4);
    chk("t3_ndone", 16'(done_cnt), 16'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("t3_order", 16'(gq[i]), 16'(i % 2));
    tick(); tick(); tick();

    // 4: overflow and its persistence
    run_op(0, 12'hFFF, 12'h001);
    chk("t4_z0a", 16'(z0), 16'h000);
    chk("t4_of0a", 16'(of0), 16'd1);
    tick();
    run_op(0, 12'h001, 12'h001);
    chk("t4_z0b", 16'(z0), 16'h002);
`ifdef OF_STICKY_EN
    chk("t4_of0b", 16'(of0), 16'd1);
`else
    chk("t4_of0b", 16'(of0), 16'd0);
`endif
    tick();

    // 5: reset in EXEC drops the op
    req1 = 1'b1; x1 = 12'h0AA; y1 = 12'h055;
    n = 0;
    do begin tick(); n++; end while (!gnt1 && n < 10);
    chk("t5_gnt1", 16'(gnt1), 16'd1);
    rst = 1'b1; req1 = 1'b0;
    tick();
    chk("t5_done1", 16'(done1), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_zero", 16'({z0, z1} | {add_x, add_y}), 16'd0);
    chk("t5_of", 16'({of0, of1}), 16'd0);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("t5_rr", 16'(gnt0), 16'd1);
    req0 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!gnt1 && n < 10);
    chk("t5_gnt1b", 16'(gnt1), 16'd1);
    req1 = 1'b0;
    tick(); tick();

    // 6: real fp12 adder
    real_mode = 1'b1;
    run_op(1, 12'h360, 12'h3C0);
    chk("t6_z1", 16'(z1), 16'h3D8);
    chk("t6_of1", 16'(of1), 16'd0);
    tick();
    real_mode = 1'b0;

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if (req0 && gnt0) req0 = 1'b0;
      else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; x0 = 12'($urandom); y0 = 12'($urandom);
      end
      if (req1 && gnt1) req1 = 1'b0;
      else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; x1 = 12'($urandom); y1 = 12'($urandom);
      end
      rst = ($urandom_range(79) == 0);
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
